sfifo_param: RTL and testbench
==============================

SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 Parameter W, default 33: data width, legal range 1..64.
REQ-002 Parameter AW, default 11: log2 depth; depth = 2**AW words, all usable, legal range 2..14.
REQ-003 Parameter AFULL_PU, default 2**AW-256: power-up almost-full threshold in words.
REQ-004 Parameter BASEADDR, default 16'h0000: first of 4 consecutive register-bus addresses.
REQ-005 clk  in  1  sole clock; all state on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i  in  34  register bus {clk, wr, addr[15:0], wrdata[15:0]}; only its wr/addr/wrdata fields are used.
REQ-008 o  out  16  register read data; drives 16'bz when addr not in BASEADDR..BASEADDR+3.
REQ-009 d  in  W  write data.
REQ-010 wen  in  1  write request.
REQ-011 ren  in  1  read request.
REQ-012 q  out  W  registered read data.
REQ-013 nempty  out  1  count != 0.
REQ-014 nwords  out  AW+1  current occupancy, 0..2**AW.
REQ-015 full  out  1  count == 2**AW.
REQ-016 nearlyfull  out  1  count >= threshold register.
REQ-017 overflow  out  1  sticky: a write was dropped.
REQ-018 underflow  out  1  sticky: a read hit an empty FIFO.

Function
REQ-019 Pointers SHALL be AW+1 bits; count = wptr - rptr, modulo 2**(AW+1); wrap is seamless.
REQ-020 wen && !full SHALL store d at mem[wptr[AW-1:0]] and increment wptr; nempty/nwords reflect it the next cycle.
REQ-021 ren && nempty SHALL load q <= mem[rptr[AW-1:0]] and increment rptr; q valid the cycle after the ren edge.
REQ-022 ren && !nempty SHALL load q <= 0 and set underflow; rptr unchanged.
REQ-023 q SHALL hold its value in cycles with no ren.
REQ-024 wen && full && !ren SHALL drop d, set overflow, and increment the 16-bit overflow counter (saturates at 16'hFFFF).
REQ-025 wen && ren while full SHALL perform both; count unchanged, no overflow.
REQ-026 wen && ren while empty SHALL accept the write, treat the read as underflow (q <= 0), and end with count 1.
REQ-027 full, nearlyfull, nempty SHALL be combinational from the registered pointers and threshold.
REQ-028 Reg BASEADDR+0 (RO): nwords zero-extended to 16 bits.
REQ-029 Reg BASEADDR+1 (RW1C): {12'b0, underflow, overflow, nearlyfull, full}; writing 1 to bit 2 or 3 clears that sticky flag; bits 0-1 ignore writes.
REQ-030 Sticky set and clear in the same cycle: set wins.
REQ-031 Reg BASEADDR+2 (RW): threshold, AW+1 bits, zero-extended on read.
REQ-032 Reg BASEADDR+3: overflow counter on read; any write clears it to 0; a simultaneous increment wins and the counter becomes 1.
REQ-033 Register writes take effect on the posedge where wr is high and the address matches.

Reset
REQ-034 rst_n low SHALL asynchronously force wptr=rptr=0, q=0, overflow=underflow=0, counter=0, threshold=AFULL_PU.
REQ-035 Reset mid-operation SHALL discard all contents; memory array is not reset, and no stale word is readable afterwards.
REQ-036 Deassertion takes effect on the first posedge with rst_n high; no synchroniser inside the block.

Structure
REQ-037 Shared package sfifo_pkg: bus width constants (34/16), register offsets 0-3, status bit positions.
REQ-038 One sub-module sfifo_ram: simple dual-port W x 2**AW array, one write port, one registered read port, no reset.

Verification (AW=4, W=8, AFULL_PU=12)
REQ-039 Reset, write 0x01..0x10 (16 words), then 1 more -> full=1, nwords=16, overflow=1, reg+3 reads 1; drained data = 0x01..0x10.
REQ-040 From empty, ren one cycle -> q=0, underflow=1, reg+1 reads 16'h0008; write 16'h0008 to reg+1 -> reads 16'h0000.
REQ-041 Write 12 words -> nearlyfull=1 at count 12, 0 at 11; set reg+2=4 -> nearlyfull=1 at count 4.
REQ-042 Full FIFO, wen&&ren for 40 cycles with an incrementing pattern -> count stays 16, no overflow, output order preserved across pointer wrap.
REQ-043 Empty FIFO, wen&&ren one cycle with d=0xAA -> nwords=1, underflow=1; next ren -> q=0xAA.
REQ-044 Write 5 words, pulse rst_n low mid-cycle -> all outputs 0 immediately without a clock edge; reg+2 reads 12; a later ren gives q=0 and underflow=1.

Source files
------------

// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared constants, register map and helpers for the parameterised FIFO
package sfifo_pkg;

  // Register bus layout: {clk, wr, addr[15:0], wrdata[15:0]}
  localparam int BUS_W       = 34;
  localparam int REG_W       = 16;
  localparam int BUS_CLK_BIT = 33;
  localparam int BUS_WR_BIT  = 32;
  localparam int BUS_ADDR_HI = 31;
  localparam int BUS_ADDR_LO = 16;
  localparam int BUS_DATA_HI = 15;

  localparam logic [15:0] NUM_REGS = 16'd4;

  // Register offsets from BASEADDR
  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_STATUS = 2'd1,
    REG_THRESH = 2'd2,
    REG_OVFCNT = 2'd3
  } reg_sel_e;

  // Status register bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_NFULL = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sfifo_param_if.sv
// rtl/sfifo_param_if.sv - FIFO data/handshake/status bundle
interface sfifo_param_if #(
  parameter int W  = 33,
  parameter int AW = 11
);
  logic [W-1:0] d;
  logic         wen;
  logic         ren;
  logic [W-1:0] q;
  logic         nempty;
  logic [AW:0]  nwords;
  logic         full;
  logic         nearlyfull;
  logic         overflow;
  logic         underflow;

  // Producer/consumer side (drives requests, observes status)
  modport master (
    output d, wen, ren,
    input  q, nempty, nwords, full, nearlyfull, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  d, wen, ren,
    output q, nempty, nwords, full, nearlyfull, overflow, underflow
  );
endinterface

// File: rtl/sfifo_ram.sv
// rtl/sfifo_ram.sv - simple dual-port storage, one write port, one registered read port
module sfifo_ram #(
  parameter int W  = 33,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  // Read port holds its last word unless a read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Storage write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data (read-before-write on address collision)
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sfifo_param.sv
// rtl/sfifo_param.sv - synchronous FIFO with status/threshold/overflow-counter registers
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int          W        = 33,
  parameter int          AW       = 11,
  parameter int          AFULL_PU = 2**AW - 256,
  parameter logic [15:0] BASEADDR = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] i,
  output logic [REG_W-1:0] o,
  sfifo_param_if.slave     fif
);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] THR_PU  = AFULL_PU[AW:0];

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, thr_q, thr_d, count;
  logic        qsel_q, qsel_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [15:0] ocnt_q, ocnt_d;
  logic        full_w, nempty_w, nfull_w;
  logic        do_wr, do_rd, ovf_evt, unf_evt;
  logic        bus_wr, reg_hit, wr_stat, wr_thr, wr_cnt;
  logic [15:0] bus_addr, bus_wdata, reg_off, reg_rdata;
  reg_sel_e    reg_sel;
  logic [W-1:0] ram_rdata;
  logic        unused_bus;

  assign bus_wr     = i[BUS_WR_BIT];
  assign bus_addr   = i[BUS_ADDR_HI:BUS_ADDR_LO];
  assign bus_wdata  = i[BUS_DATA_HI:0];
  assign unused_bus = ^{i[BUS_CLK_BIT], bus_wdata};
  assign reg_off    = bus_addr - BASEADDR;
  assign reg_hit    = reg_off < NUM_REGS;
  assign reg_sel    = reg_sel_e'(reg_off[1:0]);
  assign wr_stat    = bus_wr && reg_hit && (reg_sel == REG_STATUS);
  assign wr_thr     = bus_wr && reg_hit && (reg_sel == REG_THRESH);
  assign wr_cnt     = bus_wr && reg_hit && (reg_sel == REG_OVFCNT);

  // Occupancy is the modular pointer difference; MSB set means exactly full
  assign count    = wptr_q - rptr_q;
  assign full_w   = count[AW];
  assign nempty_w = (count != '0);
  assign nfull_w  = (count >= thr_q);

  // A read always succeeds when full, so wen&&ren at full never drops
  assign do_wr   = fif.wen && (!full_w || fif.ren);
  assign do_rd   = fif.ren && nempty_w;
  assign ovf_evt = fif.wen && full_w && !fif.ren;
  assign unf_evt = fif.ren && !nempty_w;

  // Next-state for pointers, output select, sticky flags, threshold and counter
  always_comb begin
    wptr_d = do_wr ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = do_rd ? rptr_q + PTR_ONE : rptr_q;
    qsel_d = fif.ren ? do_rd : qsel_q;
    ovf_d  = ovf_evt | (ovf_q & ~(wr_stat & bus_wdata[ST_OVF]));
    unf_d  = unf_evt | (unf_q & ~(wr_stat & bus_wdata[ST_UNF]));
    thr_d  = wr_thr ? bus_wdata[AW:0] : thr_q;
    ocnt_d = ocnt_q;
    if (ovf_evt)     ocnt_d = wr_cnt ? 16'd1 : sat_inc16(ocnt_q);
    else if (wr_cnt) ocnt_d = 16'd0;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      qsel_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      thr_q  <= THR_PU;
      ocnt_q <= 16'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      qsel_q <= qsel_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      thr_q  <= thr_d;
      ocnt_q <= ocnt_d;
    end
  end

  sfifo_ram #(.W(W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr_q[AW-1:0]),
    .wdata (fif.d),
    .re    (do_rd),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Register read mux
  always_comb begin
    reg_rdata = 16'd0;
    case (reg_sel)
      REG_COUNT:  reg_rdata = 16'(count);
      REG_STATUS: begin
        reg_rdata[ST_FULL]  = full_w;
        reg_rdata[ST_NFULL] = nfull_w;
        reg_rdata[ST_OVF]   = ovf_q;
        reg_rdata[ST_UNF]   = unf_q;
      end
      REG_THRESH: reg_rdata = 16'(thr_q);
      REG_OVFCNT: reg_rdata = ocnt_q;
      default:    reg_rdata = 16'd0;
    endcase
  end

  assign o = reg_hit ? reg_rdata : {REG_W{1'bz}};

  // q reads zero after reset or an underflow, otherwise the last RAM word
  assign fif.q          = qsel_q ? ram_rdata : '0;
  assign fif.nempty     = nempty_w;
  assign fif.nwords     = count;
  assign fif.full       = full_w;
  assign fif.nearlyfull = nfull_w;
  assign fif.overflow   = ovf_q;
  assign fif.underflow  = unf_q;
endmodule

// File: tb/tb_sfifo_param.sv
// tb/tb_sfifo_param.sv - directed vector and sequence bench for sfifo_param
module tb_sfifo_param;
  localparam int          W    = 8;
  localparam int          AW   = 4;
  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [33:0] i_bus;
  wire  [15:0] o_bus;

  sfifo_param_if #(.W(W), .AW(AW)) fif ();

  sfifo_param #(.W(W), .AW(AW), .AFULL_PU(12), .BASEADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i_bus),
    .o     (o_bus),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [7:0]  d;
    logic        wr;
    logic [1:0]  off;
    logic [15:0] wdat;
    logic [4:0]  e_nwords;
    logic [7:0]  e_q;
    logic        e_nempty;
    logic        e_unf;
    logic [15:0] e_o;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given requests; requests drop after the edge, address stays
  task automatic cyc(input logic w, input logic r, input logic [7:0] dd,
                     input logic rw, input logic [1:0] off, input logic [15:0] wd);
    fif.wen = w;
    fif.ren = r;
    fif.d   = dd;
    i_bus   = {1'b0, rw, BASE + 16'(off), wd};
    @(posedge clk);
    #1;
    fif.wen   = 1'b0;
    fif.ren   = 1'b0;
    i_bus[32] = 1'b0;
  endtask

  task automatic rdreg(input logic [1:0] off, output logic [15:0] v);
    i_bus = {1'b0, 1'b0, BASE + 16'(off), 16'h0000};
    #1;
    v = o_bus;
  endtask

  logic [15:0] rv;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 2'd0, 16'h0, 5'd1, 8'h00, 1'b1, 1'b0, 16'h0001};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 2'd0, 16'h0, 5'd2, 8'h00, 1'b1, 1'b0, 16'h0002};
    vecs[2]  = '{1'b1, 1'b1, 8'h33, 1'b0, 2'd0, 16'h0, 5'd2, 8'h11, 1'b1, 1'b0, 16'h0002};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0, 5'd1, 8'h22, 1'b1, 1'b0, 16'h0001};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 16'h0, 5'd1, 8'h22, 1'b1, 1'b0, 16'h0001};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0, 5'd0, 8'h33, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd1, 16'h0, 5'd0, 8'h00, 1'b0, 1'b1, 16'h0008};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 16'h8, 5'd0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 2'd0, 16'h0, 5'd1, 8'h00, 1'b1, 1'b1, 16'h0001};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0, 5'd0, 8'hAA, 1'b0, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 2'd1, 16'h8, 5'd0, 8'h00, 1'b0, 1'b1, 16'h0008};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 16'h8, 5'd0, 8'h00, 1'b0, 1'b0, 16'h0000};

    fif.wen = 1'b0;
    fif.ren = 1'b0;
    fif.d   = 8'h00;
    i_bus   = {1'b0, 1'b0, BASE, 16'h0000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nwords", 32'(fif.nwords), 32'd0);
    chk("rst_nempty", 32'(fif.nempty), 32'd0);
    chk("rst_full", 32'(fif.full), 32'd0);
    chk("rst_ovf_unf", 32'({fif.overflow, fif.underflow}), 32'd0);
    chk("rst_q", 32'(fif.q), 32'd0);
    rdreg(2'd2, rv);
    chk("rst_thresh", 32'(rv), 32'd12);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      cyc(vecs[k].wen, vecs[k].ren, vecs[k].d, vecs[k].wr, vecs[k].off, vecs[k].wdat);
      chk($sformatf("vec%0d_nwords", k), 32'(fif.nwords), 32'(vecs[k].e_nwords));
      chk($sformatf("vec%0d_q", k), 32'(fif.q), 32'(vecs[k].e_q));
      chk($sformatf("vec%0d_nempty", k), 32'(fif.nempty), 32'(vecs[k].e_nempty));
      chk($sformatf("vec%0d_unf", k), 32'(fif.underflow), 32'(vecs[k].e_unf));
      chk($sformatf("vec%0d_o", k), 32'(o_bus), 32'(vecs[k].e_o));
    end

    // Fill to full, then one dropped write
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1'b0, 8'(k), 1'b0, 2'd0, 16'h0);
    chk("fill_full", 32'(fif.full), 32'd1);
    chk("fill_ovf", 32'(fif.overflow), 32'd0);
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 2'd0, 16'h0);
    chk("ovf_full", 32'(fif.full), 32'd1);
    chk("ovf_nwords", 32'(fif.nwords), 32'd16);
    chk("ovf_flag", 32'(fif.overflow), 32'd1);
    rdreg(2'd3, rv);
    chk("ovf_cnt", 32'(rv), 32'd1);
    rdreg(2'd1, rv);
    chk("ovf_status", 32'(rv), 32'h0007);
    rdreg(2'd0, rv);
    chk("ovf_reg_count", 32'(rv), 32'd16);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0);
      chk($sformatf("drain%0d_q", k), 32'(fif.q), 32'(k));
      chk($sformatf("drain%0d_nf", k), 32'(fif.nearlyfull), 32'((16 - k) >= 12));
    end
    chk("drain_nempty", 32'(fif.nempty), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 16'h0);
    rdreg(2'd3, rv);
    chk("cnt_clear", 32'(rv), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 16'h4);
    chk("ovf_clear", 32'(fif.overflow), 32'd0);

    // Threshold register
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 16'h4);
    rdreg(2'd2, rv);
    chk("thr_rd", 32'(rv), 32'd4);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'hA0 + k), 1'b0, 2'd0, 16'h0);
    chk("thr_nf_at3", 32'(fif.nearlyfull), 32'd0);
    cyc(1'b1, 1'b0, 8'hA3, 1'b0, 2'd0, 16'h0);
    chk("thr_nf_at4", 32'(fif.nearlyfull), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0);
      chk($sformatf("thr_drain%0d", k), 32'(fif.q), 32'(8'hA0 + k));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 16'd12);

    // Full FIFO streaming across pointer wrap
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 8'(k), 1'b0, 2'd0, 16'h0);
    for (int n = 0; n < 40; n++) begin
      cyc(1'b1, 1'b1, 8'(16 + n), 1'b0, 2'd0, 16'h0);
      chk($sformatf("wrap%0d_q", n), 32'(fif.q), 32'(n));
      chk($sformatf("wrap%0d_nwords", n), 32'(fif.nwords), 32'd16);
      chk($sformatf("wrap%0d_ovf", n), 32'(fif.overflow), 32'd0);
    end
    cyc(1'b1, 1'b0, 8'hEE, 1'b0, 2'd0, 16'h0);
    cyc(1'b1, 1'b0, 8'hEE, 1'b0, 2'd0, 16'h0);
    rdreg(2'd3, rv);
    chk("cnt_two", 32'(rv), 32'd2);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 2'd3, 16'h0);
    rdreg(2'd3, rv);
    chk("cnt_clear_vs_inc", 32'(rv), 32'd1);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 2'd1, 16'h4);
    chk("ovf_set_wins", 32'(fif.overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 16'h4);
    chk("ovf_clear2", 32'(fif.overflow), 32'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0);
      chk($sformatf("wdrain%0d", k), 32'(fif.q), 32'(40 + k));
    end

    // Asynchronous reset mid-operation
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 16'd7);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'h50 + k), 1'b0, 2'd0, 16'h0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0);
    chk("pre_rst_q", 32'(fif.q), 32'h50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_nwords", 32'(fif.nwords), 32'd0);
    chk("arst_nempty", 32'(fif.nempty), 32'd0);
    chk("arst_q", 32'(fif.q), 32'd0);
    rdreg(2'd2, rv);
    chk("arst_thresh", 32'(rv), 32'd12);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0);
    chk("post_rst_q", 32'(fif.q), 32'd0);
    chk("post_rst_unf", 32'(fif.underflow), 32'd1);
    chk("post_rst_nwords", 32'(fif.nwords), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
